// File: rtl/uart_tx_frame_if.sv
// Byte-in / serial-out handshake bundle for uart_tx_frame.
// master = upstream byte source, slave = transmitter.
interface uart_tx_frame_if #(
  parameter int unsigned DATA_WIDTH = 8
);
  logic [DATA_WIDTH-1:0] P_DATA;
  logic                  Data_Valid;
  logic                  PAR_EN;
  logic                  PAR_TYP;
  logic                  TX_OUT;
  logic                  Busy;

  modport master (
    output P_DATA, Data_Valid, PAR_EN, PAR_TYP,
    input  TX_OUT, Busy
  );

  modport slave (
    input  P_DATA, Data_Valid, PAR_EN, PAR_TYP,
    output TX_OUT, Busy
  );
endinterface

// File: rtl/uart_tx_frame.sv
// UART frame serializer, one bit per CLK: start, data LSB first, optional parity, stop.
// Define UART_TX_TWO_STOP_EN for two stop bits (default build sends one).
module uart_tx_frame #(
  parameter int unsigned DATA_WIDTH = 8
) (
  input  logic            CLK,
  input  logic            Reset,
  uart_tx_frame_if.slave  bus
);

  localparam int unsigned CNT_W = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DATA_WIDTH - 1);

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    START  = 3'd1,
    DATA   = 3'd2,
    PARITY = 3'd3,
    STOP   = 3'd4
  } state_e;

  state_e                state_q, state_d;
  logic [CNT_W-1:0]      cnt_q, cnt_d;
  logic [DATA_WIDTH-1:0] data_q, data_d;
  logic                  par_en_q, par_en_d;
  logic                  par_typ_q, par_typ_d;
  logic                  tx_q, tx_d;
  logic                  busy_q, busy_d;
  logic                  can_accept;
`ifdef UART_TX_TWO_STOP_EN
  logic                  stop_cnt_q, stop_cnt_d;
`endif

  // Flop bank; Reset wins over any same-cycle Data_Valid.
  always_ff @(posedge CLK) begin
    if (Reset) begin
      state_q    <= IDLE;
      cnt_q      <= '0;
      data_q     <= '0;
      par_en_q   <= 1'b0;
      par_typ_q  <= 1'b0;
      tx_q       <= 1'b1;
      busy_q     <= 1'b0;
`ifdef UART_TX_TWO_STOP_EN
      stop_cnt_q <= 1'b0;
`endif
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      data_q     <= data_d;
      par_en_q   <= par_en_d;
      par_typ_q  <= par_typ_d;
      tx_q       <= tx_d;
      busy_q     <= busy_d;
`ifdef UART_TX_TWO_STOP_EN
      stop_cnt_q <= stop_cnt_d;
`endif
    end
  end

  // Next state, then outputs decoded from the next state so TX_OUT/Busy stay registered.
  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    data_d     = data_q;
    par_en_d   = par_en_q;
    par_typ_d  = par_typ_q;
    tx_d       = 1'b1;
    busy_d     = 1'b1;
    can_accept = 1'b0;
`ifdef UART_TX_TWO_STOP_EN
    stop_cnt_d = stop_cnt_q;
`endif

    unique case (state_q)
      IDLE: can_accept = 1'b1;
      START: begin
        state_d = DATA;
        cnt_d   = '0;
      end
      DATA: begin
        if (cnt_q == CNT_LAST) begin
          cnt_d   = '0;
          state_d = par_en_q ? PARITY : STOP;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      PARITY: state_d = STOP;
      STOP: begin
`ifdef UART_TX_TWO_STOP_EN
        if (stop_cnt_q) begin
          stop_cnt_d = 1'b0;
          state_d    = IDLE;
          can_accept = 1'b1;
        end else begin
          stop_cnt_d = 1'b1;
        end
`else
        state_d    = IDLE;
        can_accept = 1'b1;
`endif
      end
      default: state_d = IDLE;
    endcase

    // The final stop cycle may take the next byte, so back-to-back frames have no gap.
    if (can_accept && bus.Data_Valid) begin
      state_d   = START;
      cnt_d     = '0;
      data_d    = bus.P_DATA;
      par_en_d  = bus.PAR_EN;
      par_typ_d = bus.PAR_TYP;
    end

    unique case (state_d)
      IDLE:    busy_d = 1'b0;
      START:   tx_d   = 1'b0;
      DATA:    tx_d   = data_d[cnt_d];
      PARITY:  tx_d   = (^data_q) ^ par_typ_q;
      STOP:    tx_d   = 1'b1;
      default: busy_d = 1'b0;
    endcase
  end

  assign bus.TX_OUT = tx_q;
  assign bus.Busy   = busy_q;

endmodule
